// File: rtl/mem_access_if.sv
// Pipeline-to-memory bundle for the MEM-stage access unit.
interface mem_access_if;
  // EX-stage instruction fields
  logic        ex_valid;
  logic        ex_re_mem;
  logic        ex_we_mem;
  logic [2:0]  ex_memdata_width;
  logic [63:0] ex_addr;
  logic [63:0] ex_wdata;
  // Data-memory request/response
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  // Pipeline results
  logic        mem_stall;
  logic        ld_valid;
  logic [63:0] ld_data;
  logic        misaligned;

  // Access unit side
  modport master (
    input  ex_valid, ex_re_mem, ex_we_mem, ex_memdata_width, ex_addr, ex_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_stall, ld_valid, ld_data, misaligned
  );

  // Pipeline/memory environment side
  modport slave (
    output ex_valid, ex_re_mem, ex_we_mem, ex_memdata_width, ex_addr, ex_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_stall, ld_valid, ld_data, misaligned
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store unit: aligns stores onto byte lanes, issues a single
// data-memory request per instruction and extends load results.
module mem_access (
  input  logic         clk,
  input  logic         rstn,
  mem_access_if.master bus
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned MASKW = 8;
  localparam int unsigned WIDW  = 3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic               req_valid_q, req_valid_d;
  logic               we_q, we_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [WIDW-1:0]    width_q, width_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [MASKW-1:0]   wmask_q, wmask_d;
  logic               ld_valid_q, ld_valid_d;
  logic [XLEN-1:0]    ld_data_q, ld_data_d;
  logic               misaligned_q, misaligned_d;

  logic               mem_op_c;
  logic               aligned_c;
  logic               start_c;
  logic [MASKW-1:0]   size_mask_c;
  logic [XLEN-1:0]    lane_c;
  logic [XLEN-1:0]    ld_ext_c;

  // Size decode and natural-alignment check of the EX-stage access
  always_comb begin
    aligned_c   = 1'b1;
    size_mask_c = 8'h01;
    case (bus.ex_memdata_width[1:0])
      2'b00: begin aligned_c = 1'b1;                       size_mask_c = 8'h01; end
      2'b01: begin aligned_c = ~bus.ex_addr[0];            size_mask_c = 8'h03; end
      2'b10: begin aligned_c = (bus.ex_addr[1:0] == 2'b00);  size_mask_c = 8'h0F; end
      default: begin aligned_c = (bus.ex_addr[2:0] == 3'b000); size_mask_c = 8'hFF; end
    endcase
  end

  assign mem_op_c = bus.ex_valid & (bus.ex_re_mem | bus.ex_we_mem);
  assign start_c  = (state_q == IDLE) & mem_op_c & aligned_c;

  // Pick the addressed lane of the returned doubleword and extend it
  always_comb begin
    lane_c = bus.mem_resp_rdata >> {addr_q[2:0], 3'b000};
    case (width_q)
      3'b000:  ld_ext_c = {{56{lane_c[7]}},  lane_c[7:0]};
      3'b001:  ld_ext_c = {{48{lane_c[15]}}, lane_c[15:0]};
      3'b010:  ld_ext_c = {{32{lane_c[31]}}, lane_c[31:0]};
      3'b100:  ld_ext_c = {56'd0, lane_c[7:0]};
      3'b101:  ld_ext_c = {48'd0, lane_c[15:0]};
      3'b110:  ld_ext_c = {32'd0, lane_c[31:0]};
      default: ld_ext_c = lane_c;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    we_d         = we_q;
    addr_d       = addr_q;
    width_d      = width_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    ld_valid_d   = 1'b0;
    ld_data_d    = ld_data_q;
    misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d     = REQ;
          req_valid_d = 1'b1;
          we_d        = bus.ex_we_mem;
          addr_d      = bus.ex_addr;
          width_d     = bus.ex_memdata_width;
          wdata_d     = bus.ex_we_mem ? (bus.ex_wdata << {bus.ex_addr[2:0], 3'b000}) : '0;
          wmask_d     = bus.ex_we_mem ? (size_mask_c << bus.ex_addr[2:0]) : '0;
        end else if (mem_op_c) begin
          misaligned_d = 1'b1;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d    = DONE;
          ld_valid_d = 1'b1;
          ld_data_d  = ld_ext_c;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      width_q      <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ld_valid_q   <= 1'b0;
      ld_data_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      width_q      <= width_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      ld_valid_q   <= ld_valid_d;
      ld_data_q    <= ld_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Stall releases in DONE so upstream advances exactly once
  assign bus.mem_stall     = start_c | (state_q == REQ) | (state_q == WAIT);
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wmask = wmask_q;
  assign bus.ld_valid      = ld_valid_q;
  assign bus.ld_data       = ld_data_q;
  assign bus.misaligned    = misaligned_q;

endmodule
